lcd_sprite_engine: RTL and testbench
====================================

# lcd_sprite_engine

Parametrised successor to the single-sprite Nokia 5110 (PCD8544) drawing controller. It runs the LCD init sequence, clears the display RAM, then on request blits an SPR_W × SPR_PAGES-bank sprite from an external ROM to any bank/column position, with screen-edge clipping. It sits between top-level control logic and the existing `spi_master`, driving that block's data/start/command inputs and pacing on its `avail` strobe.

## Interface

**Parameters**
- `SPR_W`, 16: sprite width in columns (1..84).
- `SPR_PAGES`, 2: sprite height in 8-pixel banks (1..6).
- `ADDR_W`, 5: ROM address width; must satisfy 2^ADDR_W ≥ SPR_W*SPR_PAGES.
- `VOP`, 8'h90: contrast byte sent in extended mode.
- `CLR_BYTES`, 504: zero data bytes written by a clear.
- `DIV`, 16'd25000: constant driven on `div_factor`.

**Ports**
- `clock`, in, 1: system clock.
- `Reset`, in, 1: synchronous, active-high reset.
- `draw_req`, in, 1: draw sprite at `pos_x`/`pos_y`; sampled only in IDLE.
- `clear_req`, in, 1: clear the screen; sampled only in IDLE; wins over `draw_req`.
- `pos_x`, in, 7: top-left column, 0..83.
- `pos_y`, in, 3: top bank, 0..5.
- `rom_addr`, out, ADDR_W: sprite ROM address = page*SPR_W + col.
- `rom_data`, in, 8: ROM byte, valid one clock after `rom_addr`.
- `data_out`, out, 8: byte to `spi_master` `data_in`.
- `start`, out, 1: a byte is presented and valid.
- `command`, out, 1: 0 = LCD command byte, 1 = display data byte.
- `avail`, in, 1: `spi_master` has taken the presented byte.
- `div_factor`, out, 16: constant `DIV`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse at the end of init+clear, clear, or draw.
- `back`, out, 1: backlight enable, active low; 0 only during DRAW.

## Operation

**States:** INIT → CLEAR → IDLE → {CLEAR | DRAW} → IDLE.

- **INIT:** command bytes 0x21, VOP, 0x20, 0x0C.
- **CLEAR:** command bytes 0x40, 0x80, then CLR_BYTES data bytes of 0x00.
- **IDLE:** `start`=0, `busy`=0.
  - `clear_req` → CLEAR.
  - Otherwise `draw_req` → DRAW; `pos_x`/`pos_y` are latched that cycle.
  - Requests arriving while `busy` are dropped, not queued.
- **DRAW:** for each page p in 0..SPR_PAGES-1 with pos_y+p ≤ 5:
  - Send command 0x40|(pos_y+p), then command 0x80|pos_x.
  - Then, for each col c in 0..SPR_W-1 with pos_x+c ≤ 83, fetch and send data byte `rom_data`@(p*SPR_W+c).
  - Clipped columns/pages are skipped entirely: no SPI byte and no ROM fetch.
- **Out-of-range draw:** if latched pos_x > 83 or pos_y > 5, DRAW sends no bytes and pulses `done`.
- **Column/address widths:** column and address counters are wide enough to reach 84 and SPR_W*SPR_PAGES without wrap. The sum pos_x+c is computed in 8 bits.

## Timing

- **Byte handshake:** a byte (`data_out`, `command`, `start`=1) is held stable until a rising edge with `avail`=1. That edge completes the byte. `avail` while `start`=0 is ignored.
- **Command/clear bytes:** the next byte is presented on the cycle after the completing edge (back-to-back).
- **DRAW data bytes:**
  - After a completing edge: one FETCH cycle with `start`=0 and `rom_addr` set.
  - The next cycle, `data_out` <= `rom_data` and `start`=1.
  - Each data byte therefore appears 2 cycles after the previous byte completes.
- **`done`:** asserted the cycle after the last byte completes, with `busy`=0 on that same cycle.
- **Reset values:**
  - `data_out`=0, `start`=0, `command`=0, `rom_addr`=0, `done`=0.
  - `busy`=1, `back`=1, state INIT.
- **After reset:** the first byte (0x21, `command`=0, `start`=1) is presented on the first cycle after `Reset` deasserts.
- **Reset mid-operation:** any state aborts to INIT and the full init+clear reruns. No `done` is pulsed for the aborted operation.
- **Simultaneous `clear_req` and `draw_req` in IDLE:** CLEAR only; the draw is lost.

## Test plan

- **Reset, `avail` tied high:** byte stream is 21,90,20,0C (cmd), 40,80 (cmd), 504×00 (data). `done` pulses once, then `busy`=0.
- **Draw at `pos_x`=10, `pos_y`=1, defaults, ROM[a]=a:**
  - Stream: cmd 41, 8A, data 00..0F; then cmd 42, 8A, data 10..1F.
  - `back`=0 throughout; `done` pulses; 2-cycle data spacing.
- **Draw at `pos_x`=76, `pos_y`=5:** cmd 45, CC, data 00..07 only. No page 1; `rom_addr` never exceeds 7.
- **Draw at `pos_x`=90:** no `start` assertion; `done` one cycle after acceptance.
- **Random `avail` stalls:** `data_out`/`command` stable while `start`=1 and `avail`=0; no byte duplicated or skipped. Also: `draw_req` during CLEAR is ignored; `clear_req`+`draw_req` together in IDLE produce a clear only.
- **Reset asserted mid-DRAW at byte 9:** next bytes are 21,90,20,0C; no `done` for the aborted draw.

Source files
------------

// File: rtl/lcd_sprite_engine.sv
// PCD8544 (Nokia 5110) sprite controller: runs the LCD init sequence, clears display RAM,
// then blits a clipped SPR_W x SPR_PAGES-bank sprite from an external ROM through spi_master.
module lcd_sprite_engine #(
    parameter int          SPR_W     = 16,
    parameter int          SPR_PAGES = 2,
    parameter int          ADDR_W    = 5,
    parameter logic [7:0]  VOP       = 8'h90,
    parameter int          CLR_BYTES = 504,
    parameter logic [15:0] DIV       = 16'd25000
) (
    input  logic              clock,
    input  logic              Reset,
    input  logic              draw_req,
    input  logic              clear_req,
    input  logic [6:0]        pos_x,
    input  logic [2:0]        pos_y,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        data_out,
    output logic              start,
    output logic              command,
    input  logic              avail,
    output logic [15:0]       div_factor,
    output logic              busy,
    output logic              done,
    output logic              back
);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_CLEAR = 3'd1;
    localparam logic [2:0] ST_IDLE  = 3'd2;
    localparam logic [2:0] ST_PCMD  = 3'd3;
    localparam logic [2:0] ST_XCMD  = 3'd4;
    localparam logic [2:0] ST_FETCH = 3'd5;
    localparam logic [2:0] ST_DATA  = 3'd6;

    localparam int               CNT_W    = $clog2(CLR_BYTES + 3);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLR_BYTES + 1);

    logic [2:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        page_q, page_d;
    logic [6:0]        col_q, col_d;
    logic [6:0]        px_q, px_d;
    logic [2:0]        py_q, py_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [7:0]        data_out_q, data_out_d;
    logic              start_q, start_d;
    logic              command_q, command_d;
    logic              done_q, done_d;

    logic              fire;
    logic [7:0]        col_inc;
    logic [7:0]        col_sum;
    logic              col_next_ok;
    logic [3:0]        page_inc;
    logic [3:0]        page_row;
    logic              page_next_ok;

    function automatic logic [7:0] init_byte(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h21;
            2'd1:    return VOP;
            2'd2:    return 8'h20;
            default: return 8'h0C;
        endcase
    endfunction

    assign fire = start_q & avail;

    // Clip tests for the column/page after the current one; sums are widened so nothing wraps.
    assign col_inc      = {1'b0, col_q} + 8'd1;
    assign col_sum      = {1'b0, px_q} + col_inc;
    assign col_next_ok  = (col_inc < 8'(SPR_W)) && (col_sum <= 8'd83);
    assign page_inc     = {1'b0, page_q} + 4'd1;
    assign page_row     = {1'b0, py_q} + page_inc;
    assign page_next_ok = (page_inc < 4'(SPR_PAGES)) && (page_row <= 4'd5);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        page_d     = page_q;
        col_d      = col_q;
        px_d       = px_q;
        py_d       = py_q;
        rom_addr_d = rom_addr_q;
        data_out_d = data_out_q;
        start_d    = start_q;
        command_d  = command_q;
        done_d     = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (!start_q) begin
                    data_out_d = init_byte(cnt_q[1:0]);
                    command_d  = 1'b0;
                    start_d    = 1'b1;
                end else if (fire) begin
                    if (cnt_q == CNT_W'(3)) begin
                        state_d    = ST_CLEAR;
                        cnt_d      = '0;
                        data_out_d = 8'h40;
                    end else begin
                        cnt_d      = cnt_q + CNT_W'(1);
                        data_out_d = init_byte(cnt_q[1:0] + 2'd1);
                    end
                end
            end

            ST_CLEAR: begin
                if (fire) begin
                    if (cnt_q == CLR_LAST) begin
                        state_d = ST_IDLE;
                        start_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == '0) begin
                            data_out_d = 8'h80;
                            command_d  = 1'b0;
                        end else begin
                            data_out_d = 8'h00;
                            command_d  = 1'b1;
                        end
                    end
                end
            end

            ST_IDLE: begin
                start_d = 1'b0;
                if (clear_req) begin
                    state_d    = ST_CLEAR;
                    cnt_d      = '0;
                    data_out_d = 8'h40;
                    command_d  = 1'b0;
                    start_d    = 1'b1;
                end else if (draw_req) begin
                    px_d = pos_x;
                    py_d = pos_y;
                    if (pos_x > 7'd83 || pos_y > 3'd5) begin
                        done_d = 1'b1;
                    end else begin
                        state_d    = ST_PCMD;
                        page_d     = '0;
                        col_d      = '0;
                        rom_addr_d = '0;
                        data_out_d = 8'h40 | {5'b0, pos_y};
                        command_d  = 1'b0;
                        start_d    = 1'b1;
                    end
                end
            end

            ST_PCMD: begin
                if (fire) begin
                    state_d    = ST_XCMD;
                    data_out_d = 8'h80 | {1'b0, px_q};
                end
            end

            ST_XCMD: begin
                if (fire) begin
                    state_d = ST_FETCH;
                    start_d = 1'b0;
                    col_d   = '0;
                end
            end

            // rom_addr already points at this byte; advance it now so the registered ROM
            // read for the next byte is settled before this byte can complete.
            ST_FETCH: begin
                state_d    = ST_DATA;
                data_out_d = rom_data;
                command_d  = 1'b1;
                start_d    = 1'b1;
                if (col_next_ok) begin
                    rom_addr_d = rom_addr_q + ADDR_W'(1);
                end else if (page_next_ok) begin
                    rom_addr_d = ADDR_W'(page_inc) * ADDR_W'(SPR_W);
                end
            end

            ST_DATA: begin
                if (fire) begin
                    if (col_next_ok) begin
                        state_d = ST_FETCH;
                        col_d   = col_q + 7'd1;
                        start_d = 1'b0;
                    end else if (page_next_ok) begin
                        state_d    = ST_PCMD;
                        page_d     = page_q + 3'd1;
                        data_out_d = 8'h40 | {4'b0, page_row};
                        command_d  = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        start_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
                start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (Reset) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            page_q     <= '0;
            col_q      <= '0;
            px_q       <= '0;
            py_q       <= '0;
            rom_addr_q <= '0;
            data_out_q <= '0;
            start_q    <= 1'b0;
            command_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            page_q     <= page_d;
            col_q      <= col_d;
            px_q       <= px_d;
            py_q       <= py_d;
            rom_addr_q <= rom_addr_d;
            data_out_q <= data_out_d;
            start_q    <= start_d;
            command_q  <= command_d;
            done_q     <= done_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign data_out   = data_out_q;
    assign start      = start_q;
    assign command    = command_q;
    assign done       = done_q;
    assign div_factor = DIV;
    assign busy       = (state_q != ST_IDLE);
    assign back       = !(state_q == ST_PCMD || state_q == ST_XCMD ||
                          state_q == ST_FETCH || state_q == ST_DATA);

endmodule

// File: tb/tb_lcd_sprite_engine.sv
// Scoreboard bench for lcd_sprite_engine: stimulus pushes the expected byte/done stream,
// a negedge monitor pops and checks each completed byte, hold stability, spacing and done.
module tb_lcd_sprite_engine;

    localparam int         SPR_W     = 16;
    localparam int         SPR_PAGES = 2;
    localparam int         ADDR_W    = 5;
    localparam int         CLR_BYTES = 504;
    localparam logic [7:0] VOP       = 8'h90;
    localparam int         LIMIT     = 20000;

    logic              clock;
    logic              Reset;
    logic              draw_req;
    logic              clear_req;
    logic [6:0]        pos_x;
    logic [2:0]        pos_y;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic [7:0]        data_out;
    logic              start;
    logic              command;
    logic              avail;
    logic [15:0]       div_factor;
    logic              busy;
    logic              done;
    logic              back;

    lcd_sprite_engine #(
        .SPR_W(SPR_W), .SPR_PAGES(SPR_PAGES), .ADDR_W(ADDR_W),
        .VOP(VOP), .CLR_BYTES(CLR_BYTES), .DIV(16'd25000)
    ) dut (
        .clock(clock), .Reset(Reset), .draw_req(draw_req), .clear_req(clear_req),
        .pos_x(pos_x), .pos_y(pos_y), .rom_addr(rom_addr), .rom_data(rom_data),
        .data_out(data_out), .start(start), .command(command), .avail(avail),
        .div_factor(div_factor), .busy(busy), .done(done), .back(back)
    );

    typedef struct {
        bit         is_done;
        bit         cmd_bit;
        logic [7:0] data;
        bit         back;
        int         gap;
    } tok_t;

    tok_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stall_en = 0;

    logic [7:0] rom_mem [0:(1<<ADDR_W)-1];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = 8'(i);
    always @(posedge clock) rom_data <= rom_mem[rom_addr];

    always @(posedge clock) begin
        #1;
        avail = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // ---------------- reference model ----------------
    task automatic push_tok(input bit d, input bit c, input logic [7:0] v, input bit b, input int g);
        tok_t t;
        t.is_done = d; t.cmd_bit = c; t.data = v; t.back = b; t.gap = g;
        exp_q.push_back(t);
    endtask

    task automatic model_clear(input int first_gap);
        push_tok(0, 0, 8'h40, 1, first_gap);
        push_tok(0, 0, 8'h80, 1, 1);
        for (int i = 0; i < CLR_BYTES; i++) push_tok(0, 1, 8'h00, 1, 1);
        push_tok(1, 0, 8'h00, 1, 0);
    endtask

    task automatic model_init();
        push_tok(0, 0, 8'h21, 1, 0);
        push_tok(0, 0, VOP,   1, 1);
        push_tok(0, 0, 8'h20, 1, 1);
        push_tok(0, 0, 8'h0C, 1, 1);
        model_clear(1);
    endtask

    task automatic model_draw(input int x, input int y);
        if (x <= 83 && y <= 5) begin
            for (int p = 0; p < SPR_PAGES && y + p <= 5; p++) begin
                push_tok(0, 0, 8'(32'h40 + y + p), 0, (p == 0) ? 0 : 1);
                push_tok(0, 0, 8'(32'h80 + x), 0, 1);
                for (int c = 0; c < SPR_W && x + c <= 83; c++)
                    push_tok(0, 1, rom_mem[p * SPR_W + c], 0, 2);
            end
        end
        push_tok(1, 0, 8'h00, 1, 0);
    endtask

    // ---------------- monitor ----------------
    bit                prev_start = 0, prev_fire = 0, prev_acc = 0, mon_fire, mon_done_exp;
    logic [7:0]        prev_data;
    logic              prev_cmd;
    int                since_fire = 0;
    int                byte_cnt = 0;
    bit                track = 0;
    logic [ADDR_W-1:0] max_addr = '0;
    tok_t              mon_tok;

    always @(negedge clock) begin
        if (Reset) begin
            prev_start = 0; prev_fire = 0; prev_acc = 0; since_fire = 0;
        end else begin
            mon_fire = start && avail;
            if (prev_start && !prev_fire) begin
                checks++;
                if (!start || data_out !== prev_data || command !== prev_cmd) begin
                    errors++;
                    $display("FAIL hold: start=%0d data=%02h cmd=%0d required start=1 data=%02h cmd=%0d",
                             start, data_out, command, prev_data, prev_cmd);
                end
            end
            if (start && (prev_fire || !prev_start) && exp_q.size() > 0 &&
                !exp_q[0].is_done && exp_q[0].gap != 0) begin
                checks++;
                if (since_fire + 1 != exp_q[0].gap) begin
                    errors++;
                    $display("FAIL spacing: byte %02h presented %0d cycles after previous, required %0d",
                             data_out, since_fire + 1, exp_q[0].gap);
                end
            end
            mon_done_exp = (prev_fire || prev_acc) && exp_q.size() > 0 && exp_q[0].is_done;
            checks++;
            if (done !== mon_done_exp) begin
                errors++;
                $display("FAIL done: got %0d required %0d", done, mon_done_exp);
            end
            if (done && mon_done_exp) begin
                void'(exp_q.pop_front());
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_at_done: got %0d required 0", busy);
                end
            end
            if (mon_fire) begin
                byte_cnt++;
                checks++;
                if (exp_q.size() == 0 || exp_q[0].is_done) begin
                    errors++;
                    $display("FAIL unexpected_byte: got cmd=%0d data=%02h, required no byte", command, data_out);
                end else begin
                    mon_tok = exp_q.pop_front();
                    if (data_out !== mon_tok.data || command !== mon_tok.cmd_bit || back !== mon_tok.back) begin
                        errors++;
                        $display("FAIL byte: got cmd=%0d data=%02h back=%0d required cmd=%0d data=%02h back=%0d",
                                 command, data_out, back, mon_tok.cmd_bit, mon_tok.data, mon_tok.back);
                    end
                end
            end
            if (track && rom_addr > max_addr) max_addr = rom_addr;
            since_fire = mon_fire ? 0 : since_fire + 1;
            prev_start = start;
            prev_fire  = mon_fire;
            prev_data  = data_out;
            prev_cmd   = command;
            prev_acc   = !busy && (draw_req || clear_req);
        end
    end

    // ---------------- stimulus ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= LIMIT) begin
            errors++;
            $display("FAIL timeout: %0d expected items still pending, required 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic do_reset(input bit check_values);
        @(posedge clock); #1;
        Reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        if (check_values) begin
            chk("rst_data_out", 32'(data_out), 32'h0);
            chk("rst_start",    32'(start),    32'h0);
            chk("rst_command",  32'(command),  32'h0);
            chk("rst_rom_addr", 32'(rom_addr), 32'h0);
            chk("rst_done",     32'(done),     32'h0);
            chk("rst_busy",     32'(busy),     32'h1);
            chk("rst_back",     32'(back),     32'h1);
            chk("div_factor",   32'(div_factor), 32'd25000);
        end
        repeat (2) @(posedge clock);
        model_init();
        #1 Reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("first_byte", {23'b0, start, command, data_out}, {23'b0, 1'b1, 1'b0, 8'h21});
    endtask

    task automatic issue_req(input bit c, input bit d, input int x, input int y);
        @(posedge clock); #1;
        clear_req = c;
        draw_req  = d;
        pos_x     = 7'(x);
        pos_y     = 3'(y);
        if (c) model_clear(0);
        else if (d) model_draw(x, y);
        @(posedge clock); #1;
        clear_req = 1'b0;
        draw_req  = 1'b0;
    endtask

    initial begin
        int base;
        int n;
        Reset = 1'b1; draw_req = 1'b0; clear_req = 1'b0; pos_x = '0; pos_y = '0;

        do_reset(1);
        wait_idle();
        chk("idle_busy", 32'(busy), 32'h0);

        issue_req(0, 1, 10, 1);
        wait_idle();

        issue_req(0, 1, 76, 5);
        max_addr = '0;
        track = 1;
        wait_idle();
        track = 0;
        chk("max_rom_addr", 32'(max_addr), 32'd7);

        issue_req(0, 1, 90, 3);
        wait_idle();

        stall_en = 1;
        issue_req(1, 0, 0, 0);
        repeat (5) @(posedge clock);
        #1 draw_req = 1'b1; pos_x = 7'd5; pos_y = 3'd0;
        @(posedge clock); #1 draw_req = 1'b0;
        wait_idle();
        issue_req(1, 1, 20, 2);
        wait_idle();
        for (int i = 0; i < 10; i++) begin
            issue_req(0, 1, int'($urandom_range(0, 95)), int'($urandom_range(0, 7)));
            wait_idle();
        end
        issue_req(0, 1, 83, 4);
        wait_idle();

        stall_en = 0;
        repeat (2) @(posedge clock);
        base = byte_cnt;
        issue_req(0, 1, 10, 1);
        n = 0;
        while (byte_cnt < base + 9 && n < LIMIT) begin
            @(negedge clock);
            n++;
        end
        chk("reach_byte9", 32'(n < LIMIT), 32'h1);
        do_reset(0);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
